// File: rtl/param_nway_cache.sv
// param_nway_cache: N-way set-associative, write-back / write-allocate line cache
// with tree pseudo-LRU replacement and invalid-way-first victim selection.
// Optional feature macro: CACHE_PERF_CNT_EN enables saturating hit/miss/writeback
// counters. When it is undefined, the counter ports are tied to zero.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for mem_read / mem_write
// COMPARE   | tag lookup; hit completes the request, miss picks a victim
// WRITEBACK | dirty victim line is being written to memory
// ALLOCATE  | requested line is being fetched; replays COMPARE on pmem_resp
module param_nway_cache #(
  parameter int WAYS      = 2,
  parameter int SETS      = 8,
  parameter int LINE_BITS = 256,
  parameter int ADDR_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      mem_address,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [LINE_BITS/8-1:0] mem_byte_enable256,
  input  logic [LINE_BITS-1:0]   mem_wdata256,
  output logic [LINE_BITS-1:0]   mem_rdata256,
  output logic                   mem_resp,
  output logic [ADDR_W-1:0]      pmem_address,
  output logic                   pmem_read,
  output logic                   pmem_write,
  output logic [LINE_BITS-1:0]   pmem_wdata,
  input  logic [LINE_BITS-1:0]   pmem_rdata,
  input  logic                   pmem_resp,
  output logic [31:0]            hit_count,
  output logic [31:0]            miss_count,
  output logic [31:0]            wb_count
);

  localparam int BYTES = LINE_BITS / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int IDX   = $clog2(SETS);
  localparam int TAG   = ADDR_W - IDX - OFF;
  localparam int WB    = $clog2(WAYS);
  localparam int NODES = WAYS - 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF) - 64'd1);

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_WRITEBACK, S_ALLOCATE} state_t;

  state_t               state_q, state_d;
  logic [WAYS-1:0]      valid_q [SETS];
  logic [WAYS-1:0]      valid_d [SETS];
  logic [WAYS-1:0]      dirty_q [SETS];
  logic [WAYS-1:0]      dirty_d [SETS];
  logic [NODES-1:0]     plru_q  [SETS];
  logic [NODES-1:0]     plru_d  [SETS];
  logic [TAG-1:0]       tag_q   [SETS][WAYS];
  logic [TAG-1:0]       tag_d   [SETS][WAYS];
  logic [LINE_BITS-1:0] data_q  [SETS][WAYS];
  logic [LINE_BITS-1:0] data_d  [SETS][WAYS];
  logic [WB-1:0]        victim_q, victim_d;

  logic [ADDR_W-1:0]    req_line_addr;
  logic [IDX-1:0]       req_idx;
  logic [TAG-1:0]       req_tag;
  logic                 req_any;
  logic                 hit;
  logic [WB-1:0]        hit_way;
  logic [WB-1:0]        victim_sel;
  logic [LINE_BITS-1:0] hit_line;

  // Tree walk: each node bit points at the subtree holding the next victim
  // (0 = lower half, 1 = upper half). Nodes are heap-ordered from the root.
  function automatic logic [WB-1:0] plru_victim(input logic [NODES-1:0] bits);
    int   node;
    logic b;
    node = 0;
    for (int l = 0; l < WB; l++) begin
      b = 1'b0;
      for (int n = 0; n < NODES; n++) if (n == node) b = bits[n];
      node = 2 * node + 1 + (b ? 1 : 0);
    end
    return WB'(node - NODES);
  endfunction

  // Point every node on the accessed way's path away from that way.
  function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                 input logic [WB-1:0] way);
    logic [NODES-1:0] r;
    int               node;
    logic             b;
    r    = bits;
    node = 0;
    for (int l = 0; l < WB; l++) begin
      b = way[WB-1-l];
      for (int n = 0; n < NODES; n++) if (n == node) r[n] = ~b;
      node = 2 * node + 1 + (b ? 1 : 0);
    end
    return r;
  endfunction

  function automatic logic [LINE_BITS-1:0] merge_bytes(input logic [LINE_BITS-1:0] old_l,
                                                      input logic [LINE_BITS-1:0] new_l,
                                                      input logic [BYTES-1:0]     be);
    logic [LINE_BITS-1:0] r;
    r = old_l;
    for (int b = 0; b < BYTES; b++) if (be[b]) r[8*b +: 8] = new_l[8*b +: 8];
    return r;
  endfunction

  assign req_line_addr = mem_address & ~OFF_MASK;
  assign req_idx       = req_line_addr[OFF +: IDX];
  assign req_tag       = req_line_addr[ADDR_W-1 -: TAG];
  assign req_any       = mem_read | mem_write;
  assign hit_line      = data_q[req_idx][hit_way];

  // Tag lookup and victim choice for the live request index.
  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    victim_sel = plru_victim(plru_q[req_idx]);
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WB'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) victim_sel = WB'(w);
    end
  end

  // FSM next state, array updates and output decode.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    plru_d       = plru_q;
    tag_d        = tag_q;
    data_d       = data_q;
    victim_d     = victim_q;
    mem_resp     = 1'b0;
    mem_rdata256 = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state_q)
      S_IDLE: begin
        if (req_any) state_d = S_COMPARE;
      end
      S_COMPARE: begin
        if (!req_any) begin
          state_d = S_IDLE;
        end else if (hit) begin
          mem_resp        = 1'b1;
          mem_rdata256    = hit_line;
          plru_d[req_idx] = plru_touch(plru_q[req_idx], hit_way);
          if (mem_write) begin
            data_d[req_idx][hit_way]  = merge_bytes(hit_line, mem_wdata256, mem_byte_enable256);
            dirty_d[req_idx][hit_way] = 1'b1;
          end
          state_d = S_IDLE;
        end else begin
          victim_d = victim_sel;
          if (valid_q[req_idx][victim_sel] && dirty_q[req_idx][victim_sel]) state_d = S_WRITEBACK;
          else state_d = S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[req_idx][victim_q], req_idx, {OFF{1'b0}}};
        pmem_wdata   = data_q[req_idx][victim_q];
        if (pmem_resp) begin
          dirty_d[req_idx][victim_q] = 1'b0;
          state_d = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = req_line_addr;
        if (pmem_resp) begin
          data_d[req_idx][victim_q]  = pmem_rdata;
          tag_d[req_idx][victim_q]   = req_tag;
          valid_d[req_idx][victim_q] = 1'b1;
          dirty_d[req_idx][victim_q] = 1'b0;
          plru_d[req_idx]            = plru_touch(plru_q[req_idx], victim_q);
          state_d = S_COMPARE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and metadata; reset invalidates every line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      victim_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
        for (int w = 0; w < WAYS; w++) tag_q[s][w] <= '0;
      end
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
      plru_q   <= plru_d;
      tag_q    <= tag_d;
    end
  end

  // Line storage has no reset; valid bits guard its contents.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

`ifdef CACHE_PERF_CNT_EN
  logic        replay_q, replay_d;
  logic        first_cmp;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [31:0] wb_cnt_q, wb_cnt_d;

  // Count only the first COMPARE of a request; the post-fill replay is flagged.
  always_comb begin
    replay_d = replay_q;
    if (state_q == S_COMPARE) replay_d = 1'b0;
    if ((state_q == S_ALLOCATE) && pmem_resp) replay_d = 1'b1;
    first_cmp  = (state_q == S_COMPARE) && !replay_q && req_any;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    if (first_cmp && hit && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + 32'd1;
    if (first_cmp && !hit && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 32'd1;
    if ((state_q == S_WRITEBACK) && pmem_resp && (wb_cnt_q != '1)) wb_cnt_d = wb_cnt_q + 32'd1;
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      replay_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      replay_q   <= replay_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign wb_count   = wb_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
  assign wb_count   = '0;
`endif

endmodule
